// File: rtl/tinynpu_pkg.sv
// Shared TinyNPU encodings: host command opcodes, controller state codes
// and the command sequencer state enum.
package tinynpu_pkg;

    localparam logic [1:0] CMD_LDX   = 2'd0;
    localparam logic [1:0] CMD_LDW   = 2'd1;
    localparam logic [1:0] CMD_RUN   = 2'd2;
    localparam logic [1:0] CMD_DRAIN = 2'd3;

    localparam logic [1:0] ST_LD0 = 2'd0;
    localparam logic [1:0] ST_MAC = 2'd1;
    localparam logic [1:0] ST_LD1 = 2'd2;
    localparam logic [1:0] ST_OUT = 2'd3;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LDX,
        SEQ_LDW,
        SEQ_RUN_REQ,
        SEQ_RUN_WAIT,
        SEQ_DRAIN
    } seq_state_t;

endpackage

// File: rtl/tinynpu_word_cnt.sv
// Loadable up-counter with a terminal-count compare against tc_val.
// Latency: load/increment visible one cycle later; at_tc is combinational from cnt.
// Backpressure: none; the caller gates inc.
module tinynpu_word_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         at_tc
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_tc = (cnt == tc_val);

endmodule

// File: rtl/tinynpu_cmd_seq.sv
// Host command sequencer: turns LDX/LDW/RUN/DRAIN commands into TinyNPU controller strobes.
// Latency: load strobes combinational from data; resp_val one cycle after the terminating event.
// Backpressure: cmd_rdy only in IDLE, data_rdy only while loading; optional TINYNPU_CMD_SEQ_PERF_EN adds run_cycles.
module tinynpu_cmd_seq
    import tinynpu_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_val,
    output logic                     cmd_rdy,
    input  logic [1:0]               cmd_op,
    input  logic [$clog2(SIZE)-1:0]  cmd_row,
    input  logic [$clog2(SIZE):0]    cmd_len,
    input  logic                     data_val,
    output logic                     data_rdy,
    input  logic [DATA_W-1:0]        data,
    input  logic [1:0]               ctrl_state,
    output logic [DATA_W-1:0]        load_data,
    output logic                     x_load_val,
    output logic                     w_load_val,
    output logic [$clog2(SIZE)-1:0]  w_load_sel,
    output logic                     mac_val,
    output logic                     out_val,
    output logic                     resp_val,
    output logic                     busy
`ifdef TINYNPU_CMD_SEQ_PERF_EN
    ,
    output logic [31:0]              run_cycles
`endif
);

    localparam int RW = $clog2(SIZE);
    localparam int LW = RW + 1;
    localparam logic [LW-1:0] SIZE_L = LW'(SIZE);

    seq_state_t       state;
    logic [RW-1:0]    row_q;
    logic [LW-1:0]    len_q;
    logic             resp_q;
    logic [LW-1:0]    eff_len;
    logic [LW-1:0]    wcnt;
    logic             wcnt_last;
    logic             cmd_acc;
    logic             word_acc;
    logic             loading;
    logic             unused_wcnt;

    assign eff_len  = (cmd_len > SIZE_L) ? SIZE_L : cmd_len;
    assign cmd_acc  = cmd_val & cmd_rdy;
    assign word_acc = data_val & data_rdy;

    // Terminal count is eff_len-1; in IDLE len_q may be 0 but the compare is ignored there.
    tinynpu_word_cnt #(.W(LW)) u_wcnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (cmd_acc),
        .ld_val ('0),
        .inc    (word_acc),
        .tc_val (len_q - 1'b1),
        .cnt    (wcnt),
        .at_tc  (wcnt_last)
    );
    assign unused_wcnt = ^wcnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= SEQ_IDLE;
            row_q  <= '0;
            len_q  <= '0;
            resp_q <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (cmd_val) begin
                        row_q <= cmd_row;
                        len_q <= eff_len;
                        case (cmd_op)
                            CMD_LDX: begin
                                if (eff_len == '0) resp_q <= 1'b1;
                                else               state  <= SEQ_LDX;
                            end
                            CMD_LDW: begin
                                if (eff_len == '0) resp_q <= 1'b1;
                                else               state  <= SEQ_LDW;
                            end
                            CMD_RUN:   state <= SEQ_RUN_REQ;
                            default:   state <= SEQ_DRAIN;
                        endcase
                    end
                end
                SEQ_LDX, SEQ_LDW: begin
                    if (data_val && wcnt_last) begin
                        state  <= SEQ_IDLE;
                        resp_q <= 1'b1;
                    end
                end
                SEQ_RUN_REQ: begin
                    if (ctrl_state == ST_MAC) state <= SEQ_RUN_WAIT;
                end
                SEQ_RUN_WAIT: begin
                    // LD1 marks the end of the run even while write-back is still in flight.
                    if (ctrl_state == ST_LD1) begin
                        state  <= SEQ_IDLE;
                        resp_q <= 1'b1;
                    end
                end
                SEQ_DRAIN: begin
                    if (ctrl_state == ST_OUT) begin
                        state  <= SEQ_IDLE;
                        resp_q <= 1'b1;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    assign loading    = (state == SEQ_LDX) || (state == SEQ_LDW);
    assign cmd_rdy    = (state == SEQ_IDLE);
    assign data_rdy   = loading;
    assign busy       = (state != SEQ_IDLE);
    assign load_data  = loading ? data : '0;
    assign x_load_val = (state == SEQ_LDX) && data_val;
    assign w_load_val = (state == SEQ_LDW) && data_val;
    assign w_load_sel = row_q;
    assign mac_val    = (state == SEQ_RUN_REQ);
    assign out_val    = (state == SEQ_DRAIN);
    assign resp_val   = resp_q;

`ifdef TINYNPU_CMD_SEQ_PERF_EN
    logic perf_sat;
    logic in_run;

    assign in_run = (state == SEQ_RUN_REQ) || (state == SEQ_RUN_WAIT);

    tinynpu_word_cnt #(.W(32)) u_perf (
        .clk    (clk),
        .rst    (rst),
        .ld     (cmd_acc && (cmd_op == CMD_RUN)),
        .ld_val ('0),
        .inc    (in_run && !perf_sat),
        .tc_val ('1),
        .cnt    (run_cycles),
        .at_tc  (perf_sat)
    );
`endif

endmodule

// File: tb/tb_tinynpu_cmd_seq.sv
// Self-checking bench for tinynpu_cmd_seq: randomized commands against a cycle-level behavioural model.
module tb_tinynpu_cmd_seq;

    localparam int SIZE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_val;
    logic       cmd_rdy;
    logic [1:0] cmd_op;
    logic [1:0] cmd_row;
    logic [2:0] cmd_len;
    logic       data_val;
    logic       data_rdy;
    logic [7:0] data;
    logic [1:0] ctrl_state;
    logic [7:0] load_data;
    logic       x_load_val;
    logic       w_load_val;
    logic [1:0] w_load_sel;
    logic       mac_val;
    logic       out_val;
    logic       resp_val;
    logic       busy;
`ifdef TINYNPU_CMD_SEQ_PERF_EN
    logic [31:0] run_cycles;
`endif

    int checks = 0;
    int passes = 0;

    tinynpu_cmd_seq #(.SIZE(SIZE), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_val    (cmd_val),
        .cmd_rdy    (cmd_rdy),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_len    (cmd_len),
        .data_val   (data_val),
        .data_rdy   (data_rdy),
        .data       (data),
        .ctrl_state (ctrl_state),
        .load_data  (load_data),
        .x_load_val (x_load_val),
        .w_load_val (w_load_val),
        .w_load_sel (w_load_sel),
        .mac_val    (mac_val),
        .out_val    (out_val),
        .resp_val   (resp_val),
        .busy       (busy)
`ifdef TINYNPU_CMD_SEQ_PERF_EN
        ,
        .run_cycles (run_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
        $fatal(1);
    end

    // Load command; returns in the cycle resp_val is expected high.
    task automatic do_load(input bit is_w, input int row, input int len, input int mode, input bit drop_chk);
        int  eff;
        int  acc;
        int  wr;
        int  cyc;
        bit  dv;
        eff = (len > SIZE) ? SIZE : len;
        cmd_val = 1'b1; cmd_op = is_w ? 2'd1 : 2'd0;
        cmd_row = 2'(row); cmd_len = 3'(len);
        data_val = 1'b1; data = 8'hA5;
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || data_rdy !== 1'b0 || x_load_val !== 1'b0 || w_load_val !== 1'b0)
            $display("FAIL ld_accept: cmd_rdy=%b data_rdy=%b x=%b w=%b, want 1 0 0 0", cmd_rdy, data_rdy, x_load_val, w_load_val);
        else passes++;
        @(negedge clk);
        cmd_val = 1'b0;
        acc = 0; wr = 0; cyc = 0;
        while (acc < eff && cyc < 64) begin
            dv = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            data_val = dv; data = 8'($urandom);
            #1;
            checks++;
            if (data_rdy !== 1'b1 || x_load_val !== (dv && !is_w) || w_load_val !== (dv && is_w) ||
                (dv && load_data !== data) || (is_w && w_load_sel !== 2'(row)) || resp_val !== 1'b0)
                $display("FAIL ld_word: rdy=%b x=%b w=%b sel=%0d dat=%h resp=%b, want rdy=1 x=%b w=%b sel=%0d dat=%h resp=0",
                         data_rdy, x_load_val, w_load_val, w_load_sel, load_data, resp_val,
                         dv && !is_w, dv && is_w, row, data);
            else passes++;
            if (x_load_val === 1'b1 || w_load_val === 1'b1) wr++;
            if (dv) acc++;
            cyc++;
            @(negedge clk);
        end
        data_val = 1'b1; data = 8'($urandom);
        #1;
        checks++;
        if (resp_val !== 1'b1 || cmd_rdy !== 1'b1 || data_rdy !== 1'b0 || x_load_val !== 1'b0 ||
            w_load_val !== 1'b0 || wr != eff)
            $display("FAIL ld_done: resp=%b cmd_rdy=%b data_rdy=%b x=%b w=%b writes=%0d, want 1 1 0 0 0 writes=%0d",
                     resp_val, cmd_rdy, data_rdy, x_load_val, w_load_val, wr, eff);
        else passes++;
        data_val = 1'b0;
        if (drop_chk) begin
            @(negedge clk);
            #1;
            checks++;
            if (resp_val !== 1'b0 || busy !== 1'b0)
                $display("FAIL ld_resp_pulse: resp=%b busy=%b, want 0 0", resp_val, busy);
            else passes++;
        end
    endtask

    // RUN: n_a cycles without MAC, one MAC cycle, n_b cycles without LD1, then LD1.
    task automatic do_run(input int n_a, input int n_b);
        int k;
        int mac_cnt;
        bit mac_seen;
        bit done;
        logic [1:0] cs;
        cmd_val = 1'b1; cmd_op = 2'd2; cmd_row = 2'($urandom); cmd_len = 3'($urandom);
        ctrl_state = 2'd0;
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || mac_val !== 1'b0 || busy !== 1'b0)
            $display("FAIL run_accept: cmd_rdy=%b mac=%b busy=%b, want 1 0 0", cmd_rdy, mac_val, busy);
        else passes++;
        @(negedge clk);
        cmd_val = 1'b0;
        k = 0; mac_cnt = 0; mac_seen = 1'b0; done = 1'b0;
        while (!done && k < 100) begin
            k++;
            if (k <= n_a) begin
                case ($urandom_range(0, 2))
                    0: cs = 2'd0;
                    1: cs = 2'd2;
                    default: cs = 2'd3;
                endcase
            end else if (k == n_a + 1) begin
                cs = 2'd1;
            end else if (k <= n_a + 1 + n_b) begin
                case ($urandom_range(0, 2))
                    0: cs = 2'd0;
                    1: cs = 2'd1;
                    default: cs = 2'd3;
                endcase
            end else begin
                cs = 2'd2;
            end
            ctrl_state = cs;
            #1;
            checks++;
            if (mac_val !== !mac_seen || out_val !== 1'b0 || busy !== 1'b1 || cmd_rdy !== 1'b0 || resp_val !== 1'b0)
                $display("FAIL run_cycle%0d: mac=%b out=%b busy=%b cmd_rdy=%b resp=%b, want mac=%b out=0 busy=1 cmd_rdy=0 resp=0",
                         k, mac_val, out_val, busy, cmd_rdy, resp_val, !mac_seen);
            else passes++;
            if (mac_val === 1'b1) mac_cnt++;
            if (!mac_seen && cs == 2'd1) mac_seen = 1'b1;
            else if (mac_seen && cs == 2'd2) done = 1'b1;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            $display("FAIL run_timeout: LD1 never consumed after %0d cycles", k);
        end
        ctrl_state = 2'($urandom);
        #1;
        checks++;
        if (resp_val !== 1'b1 || busy !== 1'b0 || cmd_rdy !== 1'b1 || mac_val !== 1'b0 || mac_cnt != n_a + 1)
            $display("FAIL run_done: resp=%b busy=%b cmd_rdy=%b mac=%b mac_cycles=%0d, want 1 0 1 0 mac_cycles=%0d",
                     resp_val, busy, cmd_rdy, mac_val, mac_cnt, n_a + 1);
        else passes++;
`ifdef TINYNPU_CMD_SEQ_PERF_EN
        checks++;
        if (run_cycles !== 32'(n_a + n_b + 2))
            $display("FAIL run_cycles: got %0d want %0d", run_cycles, n_a + n_b + 2);
        else passes++;
`endif
    endtask

    task automatic do_drain(input int n_pre);
        int k;
        int out_cnt;
        bit done;
        logic [1:0] cs;
        cmd_val = 1'b1; cmd_op = 2'd3; cmd_row = 2'($urandom); cmd_len = 3'($urandom);
        ctrl_state = 2'd3;
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || out_val !== 1'b0)
            $display("FAIL drain_accept: cmd_rdy=%b out=%b, want 1 0", cmd_rdy, out_val);
        else passes++;
        @(negedge clk);
        cmd_val = 1'b0;
        k = 0; out_cnt = 0; done = 1'b0;
        while (!done && k < 100) begin
            k++;
            cs = (k <= n_pre) ? 2'($urandom_range(0, 2)) : 2'd3;
            ctrl_state = cs;
            #1;
            checks++;
            if (out_val !== 1'b1 || mac_val !== 1'b0 || resp_val !== 1'b0 || busy !== 1'b1)
                $display("FAIL drain_cycle%0d: out=%b mac=%b resp=%b busy=%b, want 1 0 0 1", k, out_val, mac_val, resp_val, busy);
            else passes++;
            if (out_val === 1'b1) out_cnt++;
            if (cs == 2'd3) done = 1'b1;
            @(negedge clk);
        end
        ctrl_state = 2'($urandom);
        #1;
        checks++;
        if (resp_val !== 1'b1 || out_val !== 1'b0 || cmd_rdy !== 1'b1 || out_cnt != n_pre + 1)
            $display("FAIL drain_done: resp=%b out=%b cmd_rdy=%b out_cycles=%0d, want 1 0 1 out_cycles=%0d",
                     resp_val, out_val, cmd_rdy, out_cnt, n_pre + 1);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_val = 1'b0; cmd_op = 2'd0; cmd_row = 2'd0; cmd_len = 3'd0;
        data_val = 1'b0; data = 8'h00; ctrl_state = 2'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || data_rdy !== 1'b0 || x_load_val !== 1'b0 || w_load_val !== 1'b0 ||
            w_load_sel !== 2'd0 || load_data !== 8'd0 || mac_val !== 1'b0 || out_val !== 1'b0 ||
            resp_val !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_state: cmd_rdy=%b data_rdy=%b x=%b w=%b sel=%0d dat=%h mac=%b out=%b resp=%b busy=%b, want cmd_rdy=1 rest 0",
                     cmd_rdy, data_rdy, x_load_val, w_load_val, w_load_sel, load_data, mac_val, out_val, resp_val, busy);
        else passes++;
`ifdef TINYNPU_CMD_SEQ_PERF_EN
        checks++;
        if (run_cycles !== 32'd0) $display("FAIL reset_run_cycles: got %0d want 0", run_cycles);
        else passes++;
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ldx();
        do_load(1'b0, 0, 4, 0, 1'b1);
    endtask

    task automatic test_ldw();
        do_load(1'b1, 2, 4, 1, 1'b1);
    endtask

    task automatic test_len_edges();
        do_load(1'b0, 0, 0, 0, 1'b1);
        do_load(1'b1, 3, 7, 2, 1'b1);
        do_load(1'b0, 1, 1, 0, 1'b1);
    endtask

    task automatic test_run();
        do_run(3, 5);
        @(negedge clk);
        #1;
        checks++;
        if (resp_val !== 1'b0 || mac_val !== 1'b0)
            $display("FAIL run_resp_pulse: resp=%b mac=%b, want 0 0", resp_val, mac_val);
        else passes++;
`ifdef TINYNPU_CMD_SEQ_PERF_EN
        checks++;
        if (run_cycles !== 32'd10) $display("FAIL run_cycles_hold: got %0d want 10", run_cycles);
        else passes++;
`endif
        do_run(0, 0);
    endtask

    task automatic test_drain();
        do_drain(2);
        do_drain(0);
    endtask

    task automatic test_back_to_back();
        do_load(1'b0, 1, 0, 0, 1'b0);
        do_load(1'b1, 1, 3, 0, 1'b0);
        do_run(1, 1);
        do_drain(1);
        do_load(1'b0, 0, 2, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: do_load(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 2, 1'($urandom_range(0, 1)));
                1: do_load(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 2, 1'($urandom_range(0, 1)));
                2: do_run(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
                default: do_drain(int'($urandom_range(0, 4)));
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_ldw();
        cmd_val = 1'b1; cmd_op = 2'd1; cmd_row = 2'd1; cmd_len = 3'd4; data_val = 1'b0;
        @(negedge clk);
        cmd_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_val = 1'b1; data = 8'(i + 8'h30);
            #1;
            checks++;
            if (w_load_val !== 1'b1 || w_load_sel !== 2'd1)
                $display("FAIL rst_ldw_word%0d: w=%b sel=%0d, want 1 1", i, w_load_val, w_load_sel);
            else passes++;
            @(negedge clk);
        end
        data_val = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; data_val = 1'b1; data = 8'h77;
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || busy !== 1'b0 || data_rdy !== 1'b0 || w_load_val !== 1'b0 || x_load_val !== 1'b0 ||
            load_data !== 8'd0 || w_load_sel !== 2'd0 || resp_val !== 1'b0 || mac_val !== 1'b0 || out_val !== 1'b0)
            $display("FAIL rst_mid_ldw: cmd_rdy=%b busy=%b data_rdy=%b w=%b x=%b dat=%h sel=%0d resp=%b mac=%b out=%b, want cmd_rdy=1 rest 0",
                     cmd_rdy, busy, data_rdy, w_load_val, x_load_val, load_data, w_load_sel, resp_val, mac_val, out_val);
        else passes++;
        data_val = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (resp_val !== 1'b0) $display("FAIL rst_no_resp: resp=%b want 0", resp_val);
        else passes++;
        do_load(1'b0, 0, 4, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_ldx();
        test_ldw();
        test_len_edges();
        test_run();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_mid_ldw();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
